// File: rtl/nanorv32_prefetch_q_if.sv
// nanorv32_prefetch_q_if: instruction-side AHB fetch bus and instruction output bundle
//
// Groups every non-clock/reset signal of nanorv32_prefetch_q.
//   Redirect     : flush, flush_addr
//   Instruction  : inst_valid, inst_ready, inst, inst_is_32, inst_pc, inst_err
//   AHB master   : haddri, htransi, hreadyi, hrdatai, hrespi,
//                  hsizei, hbursti, hproti, hwritei, hwdatai, hmasteri, hmasterlocki
// The master modport is the prefetch queue. The slave modport is its
// environment: the core front end plus the AHB instruction bus.
interface nanorv32_prefetch_q_if;
    logic        flush;
    logic [31:0] flush_addr;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_is_32;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [31:0] haddri;
    logic        htransi;
    logic        hreadyi;
    logic [31:0] hrdatai;
    logic        hrespi;
    logic [2:0]  hsizei;
    logic [2:0]  hbursti;
    logic [3:0]  hproti;
    logic        hwritei;
    logic [31:0] hwdatai;
    logic        hmasteri;
    logic        hmasterlocki;

    modport master (
        input  flush, flush_addr, inst_ready, hreadyi, hrdatai, hrespi,
        output inst_valid, inst, inst_is_32, inst_pc, inst_err,
               haddri, htransi, hsizei, hbursti, hproti, hwritei, hwdatai,
               hmasteri, hmasterlocki
    );

    modport slave (
        output flush, flush_addr, inst_ready, hreadyi, hrdatai, hrespi,
        input  inst_valid, inst, inst_is_32, inst_pc, inst_err,
               haddri, htransi, hsizei, hbursti, hproti, hwritei, hwdatai,
               hmasteri, hmasterlocki
    );
endinterface

// File: rtl/nanorv32_prefetch_q.sv
// nanorv32_prefetch_q: AHB instruction prefetch queue of 16-bit halfwords feeding RV32C decode
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - nanorv32_prefetch_q_if.master: redirect (flush/flush_addr),
//            instruction output (inst_*), AHB fetch master (h*i)
// Parameters:
//   DEPTH      - queue capacity in halfwords (power of 2, >= 4)
//   RESET_ADDR - first fetch address after reset
// Build option:
//   NANORV32_PREFETCH_ERR_EN - when defined, every entry carries an AHB error
//   bit, inst_err reports it and fetching halts on an errored head until flush.
//   When undefined, hrespi is ignored and inst_err is tied low.
module nanorv32_prefetch_q #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input logic                   clk,
    input logic                   rst_n,
    nanorv32_prefetch_q_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_addr;
    logic          r_dp;
    logic          r_drop;
    logic          r_dp_half;
    logic          r_next_half;
    logic          r_hold;

    logic [AW-1:0] w_rd_nxt;
    logic [AW-1:0] w_wr_nxt;
    logic [15:0]   w_head;
    logic [15:0]   w_tail;
    logic          w_is_32;
    logic          w_valid;
    logic          w_pop;
    logic          w_space;
    logic          w_stop;
    logic          w_req;
    logic          w_accept;
    logic          w_wr;
    logic [AW:0]   w_push_n;
    logic [AW:0]   w_pop_n;
    logic [31:0]   w_haddr;
    logic          w_unused;

    assign w_rd_nxt = r_rd_ptr + AW'(1);
    assign w_wr_nxt = r_wr_ptr + AW'(1);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_tail   = r_mem[w_rd_nxt];
    assign w_is_32  = w_head[1:0] == 2'b11;

    // Nothing is presented during a redirect; the head may be stale.
    assign w_valid = ~bus.flush & ((r_count >= (AW+1)'(2)) | ((r_count == (AW+1)'(1)) & ~w_is_32));
    assign w_pop   = w_valid & bus.inst_ready;
    assign w_pop_n = ~w_pop ? '0 : w_is_32 ? (AW+1)'(2) : (AW+1)'(1);

    // Reserve two entries for the data phase already in flight so a new
    // request can never overflow the queue.
    assign w_space = ({1'b0, r_count} + {{AW{1'b0}}, r_dp, 1'b0}) <= (AW+2)'(DEPTH - 2);

    // A redirect always requests; an unaccepted request is held stable as
    // AHB requires; otherwise fetch when there is room and no error stall.
    assign w_req    = bus.flush | r_hold | (w_space & ~w_stop);
    assign w_haddr  = bus.flush ? {bus.flush_addr[31:2], 2'b00} : r_fetch_addr;
    assign w_accept = w_req & bus.hreadyi;

    // Data completing in a flush cycle, or belonging to a pre-flush fetch,
    // is discarded.
    assign w_wr     = r_dp & bus.hreadyi & ~r_drop & ~bus.flush;
    assign w_push_n = ~w_wr ? '0 : r_dp_half ? (AW+1)'(1) : (AW+1)'(2);

    assign bus.inst_valid   = w_valid;
    assign bus.inst         = {w_tail, w_head};
    assign bus.inst_is_32   = w_is_32;
    assign bus.inst_pc      = r_pc;
    assign bus.haddri       = w_haddr;
    assign bus.htransi      = w_req;
    assign bus.hsizei       = 3'b010;
    assign bus.hbursti      = 3'b000;
    assign bus.hproti       = 4'b0001;
    assign bus.hwritei      = 1'b0;
    assign bus.hwdatai      = 32'h0;
    assign bus.hmasteri     = 1'b0;
    assign bus.hmasterlocki = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pc         <= RESET_ADDR;
            r_fetch_addr <= {RESET_ADDR[31:2], 2'b00};
            r_dp         <= 1'b0;
            r_drop       <= 1'b0;
            r_dp_half    <= 1'b0;
            r_next_half  <= RESET_ADDR[1];
            r_hold       <= 1'b0;
        end else begin
            r_hold <= w_req & ~bus.hreadyi;
            if (w_accept)
                r_fetch_addr <= w_haddr + 32'd4;
            else if (bus.flush)
                r_fetch_addr <= w_haddr;
            // The bus moves only on hreadyi; a flush while stalled marks the
            // in-flight data phase as stale.
            if (bus.hreadyi) begin
                r_dp   <= w_accept;
                r_drop <= 1'b0;
                if (w_accept)
                    r_dp_half <= bus.flush ? bus.flush_addr[1] : r_next_half;
            end else if (bus.flush) begin
                r_drop <= 1'b1;
            end
            // Remembers a misaligned target until its address phase is taken.
            r_next_half <= w_accept ? 1'b0 : bus.flush ? bus.flush_addr[1] : r_next_half;
            if (bus.flush) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_pc     <= {bus.flush_addr[31:1], 1'b0};
            end else begin
                r_count  <= r_count + w_push_n - w_pop_n;
                r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
                r_wr_ptr <= r_wr_ptr + w_push_n[AW-1:0];
                if (w_pop)
                    r_pc <= r_pc + (w_is_32 ? 32'd4 : 32'd2);
            end
        end
    end

    // A misaligned first word contributes only its upper halfword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= 16'h0;
        end else if (w_wr) begin
            if (r_dp_half) begin
                r_mem[r_wr_ptr] <= bus.hrdatai[31:16];
            end else begin
                r_mem[r_wr_ptr] <= bus.hrdatai[15:0];
                r_mem[w_wr_nxt] <= bus.hrdatai[31:16];
            end
        end
    end

`ifdef NANORV32_PREFETCH_ERR_EN
    logic [DEPTH-1:0] r_err;
    logic             r_err_stop;
    logic             w_head_err;

    assign w_head_err   = (r_count != '0) & r_err[r_rd_ptr];
    assign w_stop       = r_err_stop | w_head_err;
    assign bus.inst_err = r_err[r_rd_ptr] | (w_is_32 & r_err[w_rd_nxt]);
    assign w_unused     = bus.flush_addr[0];

    // Once an errored entry reaches the head, fetching stays off until the
    // core redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= '0;
            r_err_stop <= 1'b0;
        end else begin
            r_err_stop <= ~bus.flush & (r_err_stop | w_head_err);
            if (w_wr) begin
                r_err[r_wr_ptr] <= bus.hrespi;
                if (!r_dp_half)
                    r_err[w_wr_nxt] <= bus.hrespi;
            end
        end
    end
`else
    assign w_stop       = 1'b0;
    assign bus.inst_err = 1'b0;
    assign w_unused     = bus.flush_addr[0] ^ bus.hrespi;
`endif
endmodule

// File: tb/tb_nanorv32_prefetch_q.sv
// tb_nanorv32_prefetch_q: directed self-checking bench for nanorv32_prefetch_q (DEPTH=8, RESET_ADDR=0)
module tb_nanorv32_prefetch_q;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dp_valid;
    logic [31:0] dp_addr;
    logic        err_on = 1'b0;
    logic [31:0] err_addr = 32'h0;
    int          checks = 0;
    int          failures = 0;

    nanorv32_prefetch_q_if bus ();

    nanorv32_prefetch_q #(.DEPTH(8), .RESET_ADDR(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory image: halfword at byte address x is {x[13:0],2'b01} (a 16-bit op),
    // with a few hand-placed words for the redirect and straddle cases.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = a + 32'd2;
        case (a)
            32'h100: return 32'hAAAA_0001;
            32'h20C: return 32'hBEE3_5679;
            32'h210: return 32'h7771_CAFE;
            default: return {b[13:0], 2'b01, a[13:0], 2'b01};
        endcase
    endfunction

    function automatic logic [15:0] exp_hw(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // AHB slave: single-cycle data phase following each accepted address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_addr  <= 32'h0;
        end else if (bus.hreadyi) begin
            dp_valid <= bus.htransi;
            dp_addr  <= bus.haddri;
        end
    end

    assign bus.hrdatai = mem_word(dp_addr);
    assign bus.hrespi  = err_on & dp_valid & (dp_addr == err_addr);

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.flush_addr = 32'h0;
        bus.hreadyi = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.flush_addr = 32'h0;
        bus.inst_ready = 1'b0;
        bus.hreadyi = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h0 || bus.inst_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b pc=%h err=%b want 0 00000000 0", bus.inst_valid, bus.inst_pc, bus.inst_err);
        end
        checks++;
        if (bus.hsizei !== 3'b010 || bus.hbursti !== 3'b000 || bus.hproti !== 4'b0001 || bus.hwritei !== 1'b0 ||
            bus.hwdatai !== 32'h0 || bus.hmasteri !== 1'b0 || bus.hmasterlocki !== 1'b0) begin
            failures++;
            $display("FAIL const_outputs got size=%b burst=%b prot=%b write=%b wdata=%h master=%b lock=%b",
                     bus.hsizei, bus.hbursti, bus.hproti, bus.hwritei, bus.hwdatai, bus.hmasteri, bus.hmasterlocki);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.htransi !== 1'b1 || bus.haddri !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_fetch got htransi=%b haddri=%h want 1 00000000", bus.htransi, bus.haddri);
        end
    endtask

    task automatic test_stream;
        bus.inst_ready = 1'b1;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                checks++;
                if (bus.htransi !== 1'b1 || bus.haddri !== 32'(4 * c)) begin
                    failures++;
                    $display("FAIL stream_addr c=%0d got htransi=%b haddri=%h want 1 %h", c, bus.htransi, bus.haddri, 32'(4 * c));
                end
            end
            checks++;
            if (c < 2) begin
                if (bus.inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_early c=%0d got valid=%b want 0", c, bus.inst_valid);
                end
            end else if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(2 * (c - 2)) ||
                         bus.inst[15:0] !== exp_hw(32'(2 * (c - 2))) || bus.inst_is_32 !== 1'b0) begin
                failures++;
                $display("FAIL stream_inst c=%0d got valid=%b pc=%h inst=%h is32=%b want 1 %h %h 0",
                         c, bus.inst_valid, bus.inst_pc, bus.inst[15:0], bus.inst_is_32, 32'(2 * (c - 2)), exp_hw(32'(2 * (c - 2))));
            end
            step;
        end
    endtask

    task automatic test_flush_misaligned;
        bus.flush = 1'b1;
        bus.flush_addr = 32'h102;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.haddri !== 32'h100 || bus.htransi !== 1'b1) begin
            failures++;
            $display("FAIL misal_flush_cycle got valid=%b haddri=%h htransi=%b want 0 00000100 1", bus.inst_valid, bus.haddri, bus.htransi);
        end
        step;
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL misal_gap got valid=%b want 0", bus.inst_valid);
        end
        step;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h102 || bus.inst[15:0] !== 16'hAAAA) begin
            failures++;
            $display("FAIL misal_first got valid=%b pc=%h inst=%h want 1 00000102 aaaa", bus.inst_valid, bus.inst_pc, bus.inst[15:0]);
        end
        step;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h104 || bus.inst[15:0] !== exp_hw(32'h104)) begin
            failures++;
            $display("FAIL misal_second got valid=%b pc=%h inst=%h want 1 00000104 %h", bus.inst_valid, bus.inst_pc, bus.inst[15:0], exp_hw(32'h104));
        end
    endtask

    task automatic test_full;
        int          n;
        logic [31:0] pc;
        bus.inst_ready = 1'b0;
        do_reset;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.htransi === 1'b1 && bus.hreadyi === 1'b1)
                n++;
            step;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL full_fetch_count got %0d want 4", n);
        end
        checks++;
        if (bus.htransi !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL full_hold got htransi=%b valid=%b pc=%h want 0 1 00000000", bus.htransi, bus.inst_valid, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        pc = 32'h0;
        for (int k = 0; k < 12; k++) begin
            for (int t = 0; t < 10 && bus.inst_valid !== 1'b1; t++)
                step;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc || bus.inst[15:0] !== exp_hw(pc)) begin
                failures++;
                $display("FAIL full_drain k=%0d got valid=%b pc=%h inst=%h want 1 %h %h", k, bus.inst_valid, bus.inst_pc, bus.inst[15:0], pc, exp_hw(pc));
            end
            pc = pc + 32'd2;
            step;
        end
    endtask

    task automatic test_flush_pending;
        bus.inst_ready = 1'b1;
        do_reset;
        step;
        bus.flush = 1'b1;
        bus.flush_addr = 32'h300;
        bus.hreadyi = 1'b0;
        #1;
        checks++;
        if (bus.haddri !== 32'h300 || bus.htransi !== 1'b1 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_flush got haddri=%h htransi=%b valid=%b want 00000300 1 0", bus.haddri, bus.htransi, bus.inst_valid);
        end
        step;
        bus.flush = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.haddri !== 32'h300 || bus.htransi !== 1'b1 || bus.inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL pend_hold c=%0d got haddri=%h htransi=%b valid=%b want 00000300 1 0", c, bus.haddri, bus.htransi, bus.inst_valid);
            end
            step;
        end
        bus.hreadyi = 1'b1;
        #1;
        checks++;
        if (bus.haddri !== 32'h300 || bus.htransi !== 1'b1) begin
            failures++;
            $display("FAIL pend_accept got haddri=%h htransi=%b want 00000300 1", bus.haddri, bus.htransi);
        end
        step;
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_stale got valid=%b pc=%h want valid 0", bus.inst_valid, bus.inst_pc);
        end
        step;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h300 || bus.inst[15:0] !== exp_hw(32'h300)) begin
            failures++;
            $display("FAIL pend_first got valid=%b pc=%h inst=%h want 1 00000300 %h", bus.inst_valid, bus.inst_pc, bus.inst[15:0], exp_hw(32'h300));
        end
    endtask

    task automatic test_flush_replace;
        bus.flush = 1'b1;
        bus.flush_addr = 32'h400;
        #1;
        step;
        bus.flush_addr = 32'h500;
        #1;
        checks++;
        if (bus.haddri !== 32'h500 || bus.htransi !== 1'b1 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL replace_flush got haddri=%h htransi=%b valid=%b want 00000500 1 0", bus.haddri, bus.htransi, bus.inst_valid);
        end
        step;
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL replace_gap got valid=%b pc=%h want valid 0", bus.inst_valid, bus.inst_pc);
        end
        step;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h500 || bus.inst[15:0] !== exp_hw(32'h500)) begin
            failures++;
            $display("FAIL replace_first got valid=%b pc=%h inst=%h want 1 00000500 %h", bus.inst_valid, bus.inst_pc, bus.inst[15:0], exp_hw(32'h500));
        end
    endtask

    task automatic test_straddle;
        logic [31:0] pc;
        logic        is32;
        bus.flush = 1'b1;
        bus.flush_addr = 32'h200;
        #1;
        step;
        bus.flush = 1'b0;
        #1;
        pc = 32'h200;
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 10 && bus.inst_valid !== 1'b1; t++)
                step;
            is32 = pc == 32'h20E;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc || bus.inst_is_32 !== is32 ||
                (is32 ? bus.inst !== 32'hCAFE_BEE3 : bus.inst[15:0] !== exp_hw(pc))) begin
                failures++;
                $display("FAIL straddle k=%0d got valid=%b pc=%h is32=%b inst=%h want 1 %h %b %h",
                         k, bus.inst_valid, bus.inst_pc, bus.inst_is_32, bus.inst, pc, is32, is32 ? 32'hCAFE_BEE3 : {16'h0, exp_hw(pc)});
            end
            pc = pc + (is32 ? 32'd4 : 32'd2);
            step;
        end
    endtask

    task automatic test_err;
        logic [31:0] pc;
        err_on = 1'b1;
        err_addr = 32'h8;
        bus.inst_ready = 1'b1;
        do_reset;
        pc = 32'h0;
`ifdef NANORV32_PREFETCH_ERR_EN
        for (int k = 0; k < 6; k++) begin
            for (int t = 0; t < 10 && bus.inst_valid !== 1'b1; t++)
                step;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc || bus.inst_err !== (pc >= 32'h8)) begin
                failures++;
                $display("FAIL err_inst k=%0d got valid=%b pc=%h err=%b want 1 %h %b", k, bus.inst_valid, bus.inst_pc, bus.inst_err, pc, pc >= 32'h8);
            end
            if (pc >= 32'h8) begin
                checks++;
                if (bus.htransi !== 1'b0) begin
                    failures++;
                    $display("FAIL err_stop pc=%h got htransi=%b want 0", pc, bus.htransi);
                end
            end
            pc = pc + 32'd2;
            step;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.htransi !== 1'b0) begin
                failures++;
                $display("FAIL err_stay k=%0d got htransi=%b want 0", k, bus.htransi);
            end
            step;
        end
        err_on = 1'b0;
        bus.flush = 1'b1;
        bus.flush_addr = 32'h40;
        #1;
        checks++;
        if (bus.htransi !== 1'b1 || bus.haddri !== 32'h40) begin
            failures++;
            $display("FAIL err_flush got htransi=%b haddri=%h want 1 00000040", bus.htransi, bus.haddri);
        end
        step;
        bus.flush = 1'b0;
        #1;
        step;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_err !== 1'b0) begin
            failures++;
            $display("FAIL err_recover got valid=%b pc=%h err=%b want 1 00000040 0", bus.inst_valid, bus.inst_pc, bus.inst_err);
        end
`else
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 10 && bus.inst_valid !== 1'b1; t++)
                step;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc || bus.inst_err !== 1'b0) begin
                failures++;
                $display("FAIL noerr_inst k=%0d got valid=%b pc=%h err=%b want 1 %h 0", k, bus.inst_valid, bus.inst_pc, bus.inst_err, pc);
            end
            pc = pc + 32'd2;
            step;
        end
        err_on = 1'b0;
`endif
    endtask

    initial begin
        test_reset;
        test_stream;
        test_flush_misaligned;
        test_full;
        test_flush_pending;
        test_flush_replace;
        test_straddle;
        test_err;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/nanorv32_prefetch_q.md
NANORV32_PREFETCH_Q -- requirements
Module: nanorv32_prefetch_q

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in 16-bit halfword entries; power of 2, >= 4.
REQ-002 Parameter RESET_ADDR, default 32'h0: first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  redirect request (branch/trap); discards queued and in-flight data.
REQ-006 flush_addr  input  32  redirect target; halfword-aligned (bit 0 ignored).
REQ-007 inst_ready  input  1  consumer accepts the presented instruction.
REQ-008 inst_valid  output  1  a complete instruction is presented.
REQ-009 inst  output  32  instruction; 16-bit instructions in [15:0], [31:16] don't-care.
REQ-010 inst_is_32  output  1  inst[1:0] == 2'b11.
REQ-011 inst_pc  output  32  address of the presented instruction.
REQ-012 inst_err  output  1  presented instruction carries a bus error.
REQ-013 haddri  output  32  AHB address, always word-aligned.
REQ-014 htransi  output  1  AHB fetch request (NONSEQ when 1, IDLE when 0).
REQ-015 hreadyi  input  1  AHB ready; address and data phases advance only when 1.
REQ-016 hrdatai  input  32  AHB read data.
REQ-017 hrespi  input  1  AHB error response.
REQ-018 hsizei 3 = 3'b010, hbursti 3 = 3'b000, hproti 4 = 4'b0001, hwritei 1 = 0, hwdatai 32 = 0, hmasteri 1 = 0, hmasterlocki 1 = 0: constant outputs.

Function
REQ-019 Address phase accepted when htransi & hreadyi; data phase completes on the next cycle with hreadyi = 1; at most one data phase outstanding.
REQ-020 Fetch issued (htransi = 1) only when DEPTH - count - 2*outstanding >= 2, where count is the occupancy before this cycle's pop.
REQ-021 Sequential fetch address = previous accepted haddri + 4, modulo 2^32.
REQ-022 Completed data phase writes hrdatai[15:0] then hrdatai[31:16] into consecutive entries; write pointer wraps modulo DEPTH.
REQ-023 inst_valid = 1 when count >= 1 and the head halfword[1:0] != 2'b11, or when count >= 2; a 32-bit instruction may straddle the wrap point.
REQ-024 Pop when inst_valid & inst_ready: removes 1 entry (16-bit) or 2 entries (32-bit); inst_pc advances by 2 or 4.
REQ-025 Push and pop in the same cycle are both applied; count never exceeds DEPTH.
REQ-026 flush: count <- 0, both pointers <- 0, inst_pc <- {flush_addr[31:1],1'b0}; inst_valid = 0 in the flush cycle; a pop in the flush cycle is ignored.
REQ-027 flush: same cycle drives haddri = {flush_addr[31:2],2'b00}, htransi = 1; if hreadyi = 0, both are held until accepted.
REQ-028 An outstanding data phase at flush completes on the bus but its data is discarded.
REQ-029 Misaligned target (flush_addr[1] = 1): first returned word writes only hrdatai[31:16]; count += 1.
REQ-030 A flush during a flush-induced address phase replaces the target; only the latest target's data is queued.
REQ-031 Output ports are driven combinationally from queue state; the first instruction after a flush is presented 2 cycles after the flush, with zero wait states.

Reset
REQ-032 On rst_n low: count 0, pointers 0, outstanding 0, inst_valid 0, inst_pc RESET_ADDR, inst_err 0; all entries 16'h0.
REQ-033 The first cycle after reset release drives haddri = RESET_ADDR & ~3 with htransi = 1.
REQ-034 A reset asserted during a data phase abandons it; no data is written.

Configuration
REQ-035 Macro NANORV32_PREFETCH_ERR_EN defined: each entry stores an error bit written from hrespi; inst_err = OR of the error bits of the presented halfwords; further fetches stop while the head entry carries an error, until flush.
REQ-036 Macro NANORV32_PREFETCH_ERR_EN undefined: hrespi ignored; inst_err tied 0; no error storage.

Verification
REQ-037 Reset, RESET_ADDR=0, hreadyi=1, memory of 16-bit ops, inst_ready=1 -> haddri 0,4,8...; inst_pc 0,2,4,6 with one instruction per cycle.
REQ-038 DEPTH=8, inst_ready=0 -> htransi drops after 8 entries are queued (4 words); count holds at 8; no overflow.
REQ-039 flush to 32'h102 with word 0x100 = 32'hAAAA_0001 -> first instruction 16'hAAAA, inst_pc 32'h102.
REQ-040 A 32-bit instruction at entries 7/0 with DEPTH=8 -> inst = {entry0, entry7}, inst_is_32 = 1, pop of 2.
REQ-041 flush while a data phase is pending, with hreadyi=0 for 3 cycles -> stale data dropped, haddri held at the target, first inst_pc = target.
REQ-042 With NANORV32_PREFETCH_ERR_EN defined, hrespi=1 on the word at 0x8 -> inst_err=1 at inst_pc 0x8 and 0xA, htransi=0 until flush.
